booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier, successor to the 8-bit `main` multiplier. It accepts WIDTH-bit operands through a valid/ready handshake and supports both signed (two's complement) and unsigned operation, selected per transaction. It produces a 2·WIDTH-bit product after a fixed latency. It sits between the operand-entry front end and the result display/register logic.

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_step.sv | 43 ++++
 rtl/booth_mult_seq.sv | 114 +++++++++++
 tb/tb_booth_mult_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the sequential Booth multiplier.
//   state_t   : FSM state encoding (IDLE=0, CALC=1, DONE=2)
//   BOOTH_ADD : {Q[0],q-1} pair that adds the multiplicand
//   BOOTH_SUB : {Q[0],q-1} pair that subtracts the multiplicand
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   acc    in  N+1 : accumulator (one guard bit above the operand width)
//   q      in  N   : multiplier / low product register
//   qm1    in  1   : bit shifted out of q on the previous iteration
//   m      in  N   : multiplicand, already extended to N bits
//   acc_nx out N+1 : accumulator after add/sub and arithmetic shift
//   q_nx   out N   : q after the shift
//   qm1_nx out 1   : new q-1 (old q[0])
module booth_step
    import booth_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         qm1,
    input  logic [N-1:0] m,
    output logic [N:0]   acc_nx,
    output logic [N-1:0] q_nx,
    output logic         qm1_nx
);

    logic [N:0] m_ext;
    logic [N:0] sum;

    // Guard bit keeps -M representable when M is the most negative value.
    assign m_ext = {m[N-1], m};

    always_comb begin
        sum = acc;
        case ({q[0], qm1})
            BOOTH_ADD: sum = acc + m_ext;
            BOOTH_SUB: sum = acc - m_ext;
            default:   sum = acc;
        endcase
    end

    // Arithmetic right shift of {sum, q, qm1}.
    assign acc_nx = {sum[N], sum[N:1]};
    assign q_nx   = {sum[0], q[N-1:1]};
    assign qm1_nx = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, signed or unsigned
// per transaction, WIDTH-bit operands (4..32), 2*WIDTH-bit product.
//   clk    in  1         : system clock, rising edge
//   rst    in  1         : synchronous active-high reset
//   valid  in  1         : operand request, taken only while ready=1
//   sgn    in  1         : 1 = signed, 0 = unsigned, captured with operands
//   A      in  WIDTH     : multiplicand
//   B      in  WIDTH     : multiplier
//   ready  out 1         : high in IDLE
//   done   out 1         : one-cycle pulse when Y is updated
//   Y      out 2*WIDTH   : product, held until the next done
//   estado out 8         : state encoding (only with BOOTH_DEBUG_EN)
//   Q_LSB  out 2         : {Q[0],q-1}     (only with BOOTH_DEBUG_EN)
// Optional feature macro: BOOTH_DEBUG_EN.
// Latency: done/Y appear in the cycle after edge N+1, N = WIDTH+1,
// counting the acceptance edge as edge 0.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] Y
`ifdef BOOTH_DEBUG_EN
    ,
    output logic [7:0]         estado,
    output logic [1:0]         Q_LSB
`endif
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);

    state_t         state, state_nx;
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic [N:0]     acc;
    logic           qm1;
    logic [CW-1:0]  cnt;

    logic [N:0]     acc_nx;
    logic [N-1:0]   q_nx;
    logic           qm1_nx;
    logic           accept;

    booth_step #(.N(N)) u_step (
        .acc    (acc),
        .q      (q),
        .qm1    (qm1),
        .m      (m),
        .acc_nx (acc_nx),
        .q_nx   (q_nx),
        .qm1_nx (qm1_nx)
    );

    assign ready  = (state == IDLE);
    assign accept = ready && valid;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (valid) state_nx = CALC;
            CALC: if (cnt == CW'(1)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            Y     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (accept) begin
                // One extra bit: sign copy for signed, zero for unsigned.
                m   <= {sgn & A[WIDTH-1], A};
                q   <= {sgn & B[WIDTH-1], B};
                acc <= '0;
                qm1 <= 1'b0;
                cnt <= CW'(N);
            end else if (state == CALC) begin
                acc <= acc_nx;
                q   <= q_nx;
                qm1 <= qm1_nx;
                cnt <= cnt - 1'b1;
            end else if (state == DONE) begin
                // Product fits in 2*WIDTH bits in either mode.
                Y    <= {acc[WIDTH-2:0], q};
                done <= 1'b1;
            end
        end
    end

`ifdef BOOTH_DEBUG_EN
    assign estado = {6'd0, state};
    assign Q_LSB  = {q[0], qm1};
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: randomized and directed self-checking bench for
// booth_mult_seq against an integer-arithmetic reference product.
// Optional feature macro: BOOTH_DEBUG_EN (adds estado checks).
module tb_booth_mult_seq;

    localparam int W = 8;
    localparam int N = W + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic           sgn;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           ready;
    logic           done;
    logic [2*W-1:0] Y;
`ifdef BOOTH_DEBUG_EN
    logic [7:0]     estado;
    logic [1:0]     Q_LSB;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .sgn    (sgn),
        .A      (A),
        .B      (B),
        .ready  (ready),
        .done   (done),
        .Y      (Y)
`ifdef BOOTH_DEBUG_EN
        ,
        .estado (estado),
        .Q_LSB  (Q_LSB)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands read in the chosen mode.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint x, y, p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply (ready assumed high now) and check latency, ready,
    // product and that done is a single pulse. glitch=1 pulses valid with
    // other operands mid-calculation, which must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit glitch, input string tag);
        int  k;
        int  rdy_bad;
        int  st_bad;
        bit  seen;
        logic [2*W-1:0] exp;
        exp = ref_mul(a, b, s);
        A = a; B = b; sgn = s; valid = 1'b1;
        tick();
        valid = 1'b0;
        k = 0; seen = 0; rdy_bad = 0; st_bad = 0;
        while (!seen && k < 4 * N + 20) begin
            if (done) begin
                seen = 1;
            end else begin
                if (ready) rdy_bad++;
`ifdef BOOTH_DEBUG_EN
                if (estado != ((k < N) ? 8'd1 : 8'd2)) st_bad++;
`endif
                if (glitch && k == 3) begin
                    valid = 1'b1; A = ~a; B = b + 1'b1; sgn = ~s;
                end else begin
                    valid = 1'b0;
                end
                tick();
                k++;
            end
        end
        valid = 1'b0;
        chk({tag, " latency"}, 64'(k), 64'(N + 1));
        chk({tag, " ready_low"}, 64'(rdy_bad), 64'd0);
        chk({tag, " Y"}, 64'(Y), 64'(exp));
`ifdef BOOTH_DEBUG_EN
        chk({tag, " estado"}, 64'(st_bad), 64'd0);
`endif
        chk({tag, " ready_after"}, 64'(ready), 64'd1);
        tick();
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
        if (glitch) begin
            int extra;
            extra = 0;
            for (int i = 0; i < N + 4; i++) begin
                if (done) extra++;
                tick();
            end
            chk({tag, " extra_done"}, 64'(extra), 64'd0);
            chk({tag, " Y_hold"}, 64'(Y), 64'(exp));
        end
    endtask

    initial begin
        logic [W-1:0] mneg, mpos, ones;
        logic [W-1:0] a2, b2;
        logic [2*W-1:0] e1, e2;
        int  k, nd, bad;
        bit  s2;

        mneg = '0; mneg[W-1] = 1'b1;
        mpos = ~mneg;
        ones = '1;

        rst = 1'b1; valid = 1'b0; sgn = 1'b0; A = '0; B = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst Y", 64'(Y), 64'd0);
`ifdef BOOTH_DEBUG_EN
        chk("rst estado", 64'(estado), 64'd0);
        chk("rst Q_LSB", 64'(Q_LSB), 64'd0);
`endif

        run_op(W'(4), W'(2), 1'b1, 0, "s4x2");
        run_op(W'(-3), W'(5), 1'b1, 0, "sm3x5");
        run_op(mneg, mneg, 1'b1, 0, "s_minmin");
        run_op(ones, ones, 1'b0, 0, "u_ones");
        run_op(mneg, W'(2), 1'b0, 0, "u_msbx2");
        run_op(mneg, mpos, 1'b1, 0, "s_minmax");
        run_op(ones, mneg, 1'b1, 0, "s_m1xmin");
        run_op(W'(0), ones, 1'b0, 0, "u_zero");
        run_op(W'(11), W'(13), 1'b0, 1, "glitch");

        // Abort mid-calculation with reset.
        A = W'(9); B = W'(9); sgn = 1'b0; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ready", 64'(ready), 64'd1);
        chk("abort Y", 64'(Y), 64'd0);
        chk("abort done", 64'(done), 64'd0);
`ifdef BOOTH_DEBUG_EN
        chk("abort estado", 64'(estado), 64'd0);
`endif
        nd = 0;
        for (int i = 0; i < N + 4; i++) begin
            if (done) nd++;
            tick();
        end
        chk("abort no_done", 64'(nd), 64'd0);
        run_op(W'(7), W'(6), 1'b1, 0, "post_abort");

        // Back-to-back: valid held high, second op taken on first IDLE edge.
        e1 = ref_mul(W'(25), W'(-4), 1'b1);
        a2 = W'($urandom); b2 = W'($urandom); s2 = 1'($urandom);
        e2 = ref_mul(a2, b2, s2);
        A = W'(25); B = W'(-4); sgn = 1'b1; valid = 1'b1;
        tick();
        A = a2; B = b2; sgn = s2;
        k = 0; nd = 0; bad = 0;
        while (nd < 2 && k < 6 * N + 20) begin
            if (done) begin
                nd++;
                if (nd == 1) begin
                    chk("b2b first_lat", 64'(k), 64'(N + 1));
                    chk("b2b first_Y", 64'(Y), 64'(e1));
                end else begin
                    valid = 1'b0;
                    chk("b2b second_lat", 64'(k), 64'(2 * N + 3));
                    chk("b2b second_Y", 64'(Y), 64'(e2));
                end
            end
            if (nd < 2) begin
                tick();
                k++;
            end
        end
        valid = 1'b0;
        chk("b2b count", 64'(nd), 64'd2);
        tick();

        // Randomized operands and modes.
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
